mul_pipe_asic: RTL

// - Parametrised, pipelined integer multiplier with valid/ready flow control; next generation of the

---
 rtl/mul_pipe_asic.sv | 80 ++++++++
 1 files changed

// File: rtl/mul_pipe_asic.sv
// Pipelined AWxBW integer multiplier with valid/ready flow control and a TAG sideband.
// Define MUL_PIPE_SIGNED_EN to add the per-pair SIGNED (two's-complement) mode port.
module mul_pipe_asic #(
    parameter int unsigned AW     = 17,
    parameter int unsigned BW     = 17,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TW     = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [AW-1:0]    A,
    input  logic [BW-1:0]    B,
    input  logic [TW-1:0]    TAG,
`ifdef MUL_PIPE_SIGNED_EN
    input  logic             SIGNED,
`endif
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [AW+BW-1:0] P,
    output logic [TW-1:0]    P_TAG
);

    localparam int unsigned PW = AW + BW;

    logic              adv;
    logic [PW-1:0]     a_ext;
    logic [PW-1:0]     b_ext;
    logic [PW-1:0]     prod_d;
    logic [STAGES-1:0] valid_q;
    logic [PW-1:0]     prod_q [STAGES];
    logic [TW-1:0]     tag_q  [STAGES];

    // One enable for every rank: the pipe moves only when the output slot is free or being taken.
    assign adv      = !OUT_VALID || OUT_READY;
    assign IN_READY = adv;

    // The product is formed ahead of rank 0; the ranks behind it are retimed into the array.
    always_comb begin
`ifdef MUL_PIPE_SIGNED_EN
        if (SIGNED) begin
            a_ext = {{BW{A[AW-1]}}, A};
            b_ext = {{AW{B[BW-1]}}, B};
        end else begin
            a_ext = {{BW{1'b0}}, A};
            b_ext = {{AW{1'b0}}, B};
        end
`else
        a_ext = {{BW{1'b0}}, A};
        b_ext = {{AW{1'b0}}, B};
`endif
        prod_d = a_ext * b_ext;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                prod_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (adv) begin
            valid_q[0] <= IN_VALID;
            prod_q[0]  <= prod_d;
            tag_q[0]   <= TAG;
            // Bubbles shift along with data; they are never collapsed.
            for (int i = 1; i < int'(STAGES); i++) begin
                valid_q[i] <= valid_q[i-1];
                prod_q[i]  <= prod_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign OUT_VALID = valid_q[STAGES-1];
    assign P         = prod_q[STAGES-1];
    assign P_TAG     = tag_q[STAGES-1];

endmodule
